// File: rtl/uart_rx.sv
// uart_rx: fixed-table asynchronous serial receiver for a 100 MHz clock.
//
// Ports
//   clk    system clock, all state updates on the rising edge
//   rst    synchronous active-low reset
//   Rx     asynchronous serial line, idle high
//   eight  1 = 8 data bits, 0 = 7 data bits
//   pen    1 = parity bit follows the data bits
//   ohel   parity sense: 1 = odd, 0 = even
//   baud   bit-rate select (table in bit_time)
//   clr    read acknowledge, clears RxRdy/PERR/FERR/OVF
//   data   last received character (data[7]=0 in 7-bit mode)
//   RxRdy  character available
//   PERR   parity error on the last character
//   FERR   stop bit of the last character was 0
//   OVF    a character completed while RxRdy was still set
//
// Handshake: RxRdy rises one cycle after the stop-bit sample and stays
// high until clr=1 is seen on a rising edge; a completion in the same
// cycle as clr wins, so the new character is never lost to the clear.
module uart_rx (
   input  logic       clk,
   input  logic       rst,
   input  logic       Rx,
   input  logic       eight,
   input  logic       pen,
   input  logic       ohel,
   input  logic [3:0] baud,
   input  logic       clr,
   output logic [7:0] data,
   output logic       RxRdy,
   output logic       PERR,
   output logic       FERR,
   output logic       OVF
);

   typedef enum logic [1:0] {IDLE, START, SHIFT, STOP} state_t;

   state_t      state, state_n;
   logic        s1, s2, rxs;
   logic [18:0] cnt, t_lat, h_lat;
   logic [3:0]  bitcnt, last_bit;
   logic [8:0]  sr;
   logic        eight_l, pen_l, ohel_l;
   logic        armed, done_q, stop_q;
   logic        start_frame, bit_take, stop_take, cnt_restart;
   logic        tick_h, tick_t;
   logic [7:0]  rx_data;
   logic        rx_par, par_err;

   function automatic logic [18:0] bit_time(input logic [3:0] b);
      case (b)
         4'b0000: bit_time = 19'd333333;
         4'b0001: bit_time = 19'd83333;
         4'b0010: bit_time = 19'd41667;
         4'b0011: bit_time = 19'd20833;
         4'b0100: bit_time = 19'd10417;
         4'b0101: bit_time = 19'd5208;
         4'b0110: bit_time = 19'd2604;
         4'b0111: bit_time = 19'd1736;
         4'b1000: bit_time = 19'd868;
         4'b1001: bit_time = 19'd434;
         4'b1010: bit_time = 19'd217;
         default: bit_time = 19'd109;
      endcase
   endfunction

   assign rxs      = s2;
   assign h_lat    = t_lat >> 1;
   assign tick_h   = (cnt == h_lat - 19'd1);
   assign tick_t   = (cnt == t_lat - 19'd1);
   // Index of the final bit held in sr: data bits first, parity last.
   assign last_bit = (eight_l ? 4'd7 : 4'd6) + {3'd0, pen_l};

   assign rx_data = eight_l ? sr[7:0] : {1'b0, sr[6:0]};
   assign rx_par  = eight_l ? sr[8] : sr[7];
   // Even parity expects XOR of the data bits; odd parity its inverse.
   assign par_err = pen_l & (rx_par ^ (^rx_data) ^ ohel_l);

   // Two-flop synchronizer, preset to the idle level.
   always_ff @(posedge clk) begin
      if (!rst) begin
         s1 <= 1'b1;
         s2 <= 1'b1;
      end else begin
         s1 <= Rx;
         s2 <= s1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) state <= IDLE;
      else      state <= state_n;
   end

   always_comb begin
      state_n     = state;
      start_frame = 1'b0;
      bit_take    = 1'b0;
      stop_take   = 1'b0;
      cnt_restart = 1'b0;
      case (state)
         IDLE: begin
            // armed blocks a restart until the line has been seen idle.
            if (armed && !rxs) begin
               state_n     = START;
               start_frame = 1'b1;
            end
         end
         START: begin
            if (tick_h) begin
               cnt_restart = 1'b1;
               state_n     = rxs ? IDLE : SHIFT;
            end
         end
         SHIFT: begin
            if (tick_t) begin
               cnt_restart = 1'b1;
               bit_take    = 1'b1;
               if (bitcnt == last_bit) state_n = STOP;
            end
         end
         STOP: begin
            if (tick_t) begin
               cnt_restart = 1'b1;
               stop_take   = 1'b1;
               state_n     = IDLE;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         cnt     <= '0;
         t_lat   <= '0;
         bitcnt  <= '0;
         sr      <= '0;
         eight_l <= 1'b0;
         pen_l   <= 1'b0;
         ohel_l  <= 1'b0;
         armed   <= 1'b0;
         done_q  <= 1'b0;
         stop_q  <= 1'b0;
      end else begin
         done_q <= stop_take;
         if (stop_take) stop_q <= rxs;

         if (state == IDLE && rxs) armed <= 1'b1;
         else if (stop_take)       armed <= 1'b0;

         if (start_frame) begin
            eight_l <= eight;
            pen_l   <= pen;
            ohel_l  <= ohel;
            t_lat   <= bit_time(baud);
            sr      <= '0;
            bitcnt  <= '0;
            cnt     <= '0;
         end else if (state == IDLE || cnt_restart) begin
            cnt <= '0;
         end else begin
            cnt <= cnt + 19'd1;
         end

         if (bit_take) begin
            sr[bitcnt] <= rxs;
            bitcnt     <= bitcnt + 4'd1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         data  <= 8'h00;
         RxRdy <= 1'b0;
         PERR  <= 1'b0;
         FERR  <= 1'b0;
         OVF   <= 1'b0;
      end else if (done_q) begin
         data  <= rx_data;
         RxRdy <= 1'b1;
         FERR  <= ~stop_q;
         PERR  <= par_err;
         OVF   <= RxRdy & ~clr;
      end else if (clr) begin
         RxRdy <= 1'b0;
         PERR  <= 1'b0;
         FERR  <= 1'b0;
         OVF   <= 1'b0;
      end
   end

endmodule

// File: tb/tb_uart_rx.sv
module tb_uart_rx;

   localparam int BT = 109;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       Rx = 1'b1;
   logic       eight = 1'b1;
   logic       pen = 1'b1;
   logic       ohel = 1'b0;
   logic [3:0] baud = 4'b1011;
   logic       clr = 1'b0;
   logic [7:0] data;
   logic       RxRdy, PERR, FERR, OVF;

   int n_checks = 0;
   int n_fail   = 0;

   uart_rx dut (
      .clk(clk), .rst(rst), .Rx(Rx), .eight(eight), .pen(pen), .ohel(ohel),
      .baud(baud), .clr(clr), .data(data), .RxRdy(RxRdy), .PERR(PERR),
      .FERR(FERR), .OVF(OVF)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic send_bit(input logic b);
      Rx = b;
      repeat (BT) @(negedge clk);
   endtask

   // mangle flips the frame-format inputs after the start bit to show
   // that the frame in flight keeps the format latched at its start.
   task automatic send_frame(input logic [7:0] d, input int nd, input logic has_par,
                             input logic pbit, input logic stopb, input logic mangle);
      logic       e_s, p_s, o_s;
      logic [3:0] b_s;
      e_s = eight; p_s = pen; o_s = ohel; b_s = baud;
      send_bit(1'b0);
      if (mangle) begin
         eight = ~eight; pen = ~pen; ohel = ~ohel; baud = 4'b0000;
      end
      for (int i = 0; i < nd; i++) send_bit(d[i]);
      if (has_par) send_bit(pbit);
      send_bit(stopb);
      Rx = 1'b1;
      eight = e_s; pen = p_s; ohel = o_s; baud = b_s;
   endtask

   task automatic clr_pulse();
      @(negedge clk) clr = 1'b1;
      @(negedge clk) clr = 1'b0;
   endtask

   initial begin
      logic [7:0] d43;
      d43 = 8'h43;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check("reset data", data, 8'h00);
      check("reset rxrdy", RxRdy, 1'b0);
      check("reset perr", PERR, 1'b0);
      check("reset ferr", FERR, 1'b0);
      check("reset ovf", OVF, 1'b0);
      check("reset state", int'(dut.state), 0);
      repeat (5) @(negedge clk);

      // 8E1, 0x43 has three ones -> even parity bit 1
      send_frame(8'h43, 8, 1'b1, 1'b1, 1'b1, 1'b0);
      check("even data", data, 8'h43);
      check("even rxrdy", RxRdy, 1'b1);
      check("even perr", PERR, 1'b0);
      check("even ferr", FERR, 1'b0);
      check("even ovf", OVF, 1'b0);
      clr_pulse();
      check("clr rxrdy", RxRdy, 1'b0);
      check("clr keeps data", data, 8'h43);

      // Same bits with odd sense -> parity error
      ohel = 1'b1;
      send_frame(8'h43, 8, 1'b1, 1'b1, 1'b1, 1'b0);
      check("odd data", data, 8'h43);
      check("odd rxrdy", RxRdy, 1'b1);
      check("odd perr", PERR, 1'b1);
      clr_pulse();
      check("clr perr", PERR, 1'b0);
      ohel = 1'b0;

      // Format inputs changed mid-frame
      send_frame(8'h43, 8, 1'b1, 1'b1, 1'b1, 1'b1);
      check("mangle data", data, 8'h43);
      check("mangle perr", PERR, 1'b0);
      check("mangle ferr", FERR, 1'b0);
      clr_pulse();

      // Back-to-back without clr -> overrun
      send_frame(8'h41, 8, 1'b1, 1'b0, 1'b1, 1'b0);
      check("b2b first data", data, 8'h41);
      check("b2b first ovf", OVF, 1'b0);
      send_frame(8'h42, 8, 1'b1, 1'b0, 1'b1, 1'b0);
      check("b2b second data", data, 8'h42);
      check("b2b second rxrdy", RxRdy, 1'b1);
      check("b2b second ovf", OVF, 1'b1);
      clr_pulse();
      check("clr ovf", OVF, 1'b0);

      // 7N1 with a bad stop bit
      eight = 1'b0; pen = 1'b0;
      send_frame(8'h55, 7, 1'b0, 1'b0, 1'b0, 1'b0);
      check("7bit data", data, 8'h55);
      check("7bit ferr", FERR, 1'b1);
      check("7bit perr", PERR, 1'b0);
      check("7bit rxrdy", RxRdy, 1'b1);
      repeat (20) @(negedge clk);
      clr_pulse();
      check("clr ferr", FERR, 1'b0);
      check("clr rxrdy 2", RxRdy, 1'b0);
      check("clr keeps data 2", data, 8'h55);
      eight = 1'b1; pen = 1'b1;

      // Glitch shorter than half a bit
      Rx = 1'b0;
      repeat (30) @(negedge clk);
      Rx = 1'b1;
      repeat (200) @(negedge clk);
      check("glitch rxrdy", RxRdy, 1'b0);
      check("glitch state", int'(dut.state), 0);
      send_frame(8'h43, 8, 1'b1, 1'b1, 1'b1, 1'b0);
      check("post glitch data", data, 8'h43);
      check("post glitch rxrdy", RxRdy, 1'b1);
      clr_pulse();

      // Reset after the 4th data bit aborts the frame
      send_bit(1'b0);
      for (int i = 0; i < 4; i++) send_bit(d43[i]);
      rst = 1'b0;
      Rx  = 1'b1;
      repeat (5) @(negedge clk);
      rst = 1'b1;
      repeat (1500) @(negedge clk);
      check("abort rxrdy", RxRdy, 1'b0);
      check("abort data", data, 8'h00);
      send_frame(8'h43, 8, 1'b1, 1'b1, 1'b1, 1'b0);
      check("after abort data", data, 8'h43);
      check("after abort rxrdy", RxRdy, 1'b1);
      check("after abort perr", PERR, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
